// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared constants and types for the rate-1/2, K=7
// convolutional encoder (conv_enc_core / conv_encoder).
package conv_enc_pkg;

    localparam int unsigned K = 7;

    // Generators: MSB taps the current input bit, LSB the oldest bit.
    localparam logic [K-1:0] G0_DEFAULT = 7'o171;
    localparam logic [K-1:0] G1_DEFAULT = 7'o133;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    // Encoded symbol {c1, c0}.
    typedef logic [1:0] symbol_t;

    // Parity of the generator-masked encoding window.
    function automatic logic tap_parity(input logic [K-1:0] w, input logic [K-1:0] g);
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: K-1 bit history shift register plus parity generation.
// sym is the symbol for the current bit u; the history advances on step
// and is forced to zero on clear (frame end).
module conv_enc_core
    import conv_enc_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    step,
    input  logic    clear,
    input  logic    u,
    output symbol_t sym
);

    logic [K-2:0] sr;
    logic [K-1:0] w;

    // Encoding window with the current bit on top and the oldest bit at w[0].
    always_comb begin
        w   = {u, sr};
        sym = {tap_parity(w, G1), tap_parity(w, G0)};
    end

    // History register: shift on each encode step, clear at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (step) begin
            sr <= w[K-1:1];
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, K=7 convolutional encoder with frame handshake
// and TAIL_LEN zero-bit trellis termination.
// Optional build macro CONV_ENC_ERR_INJ_EN adds per-frame symbol error
// injection (err_inj_en / err_inj_idx / err_inj_mask).
module conv_encoder
    import conv_enc_pkg::*;
#(
    parameter int unsigned  FRAME_LEN = 512,
    parameter int unsigned  TAIL_LEN  = 32,
    parameter logic [K-1:0] G0        = G0_DEFAULT,
    parameter logic [K-1:0] G1        = G1_DEFAULT
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        bit_in_valid,
    input  logic        bit_in,
`ifdef CONV_ENC_ERR_INJ_EN
    input  logic        err_inj_en,
    input  logic [15:0] err_inj_idx,
    input  logic [1:0]  err_inj_mask,
`endif
    output logic        bit_in_ready,
    output logic        d_out_valid,
    output logic [1:0]  d_out,
    output logic        frame_done
);

    localparam int unsigned BIT_W  = $clog2(FRAME_LEN + 1);
    localparam int unsigned TAIL_W = $clog2(TAIL_LEN + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_LEN - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);

    enc_state_t        state, state_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [TAIL_W-1:0] tail_cnt;
    logic              hs, bit_last, tail_last, step, u, ready_nxt;
    symbol_t           sym, sym_out;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk   (clk),
        .rst_n (RSTn),
        .step  (step),
        .clear (tail_last),
        .u     (u),
        .sym   (sym)
    );

    // State register.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE and DATA share the accept path; the last data
    // bit hands over to TAIL, the last tail step returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DATA: if (hs) state_nxt = bit_last ? TAIL : DATA;
            TAIL:       if (tail_last) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Step control: accepted bits in IDLE/DATA, forced zero bits in TAIL.
    always_comb begin
        hs        = bit_in_valid & bit_in_ready;
        bit_last  = hs && (bit_cnt == BIT_LAST);
        tail_last = (state == TAIL) && (tail_cnt == TAIL_LAST);
        ready_nxt = (state_nxt != TAIL);
        step      = 1'b0;
        u         = 1'b0;
        case (state)
            IDLE, DATA: begin
                step = hs;
                u    = bit_in;
            end
            TAIL: begin
                step = 1'b1;
                u    = 1'b0;
            end
            default: ;
        endcase
    end

    // Frame counters; each clears on its own terminal step.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            bit_cnt  <= '0;
            tail_cnt <= '0;
        end else begin
            if (hs && state != TAIL) begin
                bit_cnt <= bit_last ? '0 : bit_cnt + BIT_W'(1);
            end
            if (state == TAIL) begin
                tail_cnt <= tail_last ? '0 : tail_cnt + TAIL_W'(1);
            end
        end
    end

`ifdef CONV_ENC_ERR_INJ_EN
    logic [31:0] sym_idx;

    // Symbol index within the frame comes straight from the counters, so no
    // separate index register is needed.
    always_comb begin
        sym_idx = (state == TAIL) ? 32'(FRAME_LEN) + 32'(tail_cnt) : 32'(bit_cnt);
        sym_out = sym;
        if (err_inj_en && (sym_idx == {16'b0, err_inj_idx})) begin
            sym_out = sym ^ err_inj_mask;
        end
    end
`else
    // Clean code path.
    always_comb begin
        sym_out = sym;
    end
`endif

    // Registered outputs; d_out holds between encode steps.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            bit_in_ready <= 1'b0;
            d_out_valid  <= 1'b0;
            d_out        <= '0;
            frame_done   <= 1'b0;
        end else begin
            bit_in_ready <= ready_nxt;
            d_out_valid  <= step;
            frame_done   <= tail_last;
            if (step) begin
                d_out <= sym_out;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed self-checking bench for conv_encoder.
`timescale 1ns/1ps
module tb_conv_encoder;

    localparam int FRAME_LEN = 512;
    localparam int TAIL_LEN  = 32;
    localparam int FS        = FRAME_LEN + TAIL_LEN;

    logic       clk          = 1'b0;
    logic       RSTn         = 1'b0;
    logic       bit_in_valid = 1'b0;
    logic       bit_in       = 1'b0;
    logic       bit_in_ready, d_out_valid, frame_done;
    logic [1:0] d_out;
`ifdef CONV_ENC_ERR_INJ_EN
    logic        err_inj_en   = 1'b0;
    logic [15:0] err_inj_idx  = '0;
    logic [1:0]  err_inj_mask = '0;
`endif

    conv_encoder #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .G0        (7'o171),
        .G1        (7'o133)
    ) dut (
        .clk          (clk),
        .RSTn         (RSTn),
        .bit_in_valid (bit_in_valid),
        .bit_in       (bit_in),
`ifdef CONV_ENC_ERR_INJ_EN
        .err_inj_en   (err_inj_en),
        .err_inj_idx  (err_inj_idx),
        .err_inj_mask (err_inj_mask),
`endif
        .bit_in_ready (bit_in_ready),
        .d_out_valid  (d_out_valid),
        .d_out        (d_out),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Hand-computed leading symbols {c1,c0} for G0=171, G1=133.
    logic [1:0] imp_syms  [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [1:0] ones_syms [7] = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // ---------------- monitor ----------------
    logic [1:0] rx_sym[$];
    bit         rx_done[$];
    int         runs[$];
    int         cyc = 0, first_hs = -1, first_v = -1, last_v = -1, n_valid = 0;
    int         done_cnt = 0, stray_done = 0, hold_err = 0, ready_run = 0;
    logic [1:0] last_d = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bit_in_valid && bit_in_ready && first_hs < 0) first_hs <= cyc + 1;
    end

    always @(negedge clk) begin
        if (d_out_valid) begin
            rx_sym.push_back(d_out);
            rx_done.push_back(frame_done);
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            n_valid++;
            if (frame_done) done_cnt++;
        end else begin
            if (frame_done) stray_done++;
            if (RSTn && d_out !== last_d) hold_err++;
        end
        last_d = d_out;
        if (!bit_in_ready) ready_run++;
        else begin
            if (ready_run > 0) runs.push_back(ready_run);
            ready_run = 0;
        end
    end

    // ---------------- reference model ----------------
    bit         tx[FRAME_LEN];
    logic [1:0] exp_sym[$];
    bit         exp_done[$];

    function automatic bit ub(input bit u[FS], input int n);
        return (n >= 0) ? u[n] : 1'b0;
    endfunction

    // Convolution sum written as generator tap delays: 171 -> 0,1,2,3,6; 133 -> 0,2,3,5,6.
    task automatic model_frame();
        bit u[FS];
        bit c0, c1;
        for (int n = 0; n < FS; n++) u[n] = (n < FRAME_LEN) ? tx[n] : 1'b0;
        for (int n = 0; n < FS; n++) begin
            c0 = ub(u, n) ^ ub(u, n-1) ^ ub(u, n-2) ^ ub(u, n-3) ^ ub(u, n-6);
            c1 = ub(u, n) ^ ub(u, n-2) ^ ub(u, n-3) ^ ub(u, n-5) ^ ub(u, n-6);
            exp_sym.push_back({c1, c0});
            exp_done.push_back(n == FS - 1);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < FRAME_LEN; i++) begin
            case (pat)
                0:       tx[i] = (i == 0);
                1:       tx[i] = 1'b0;
                2:       tx[i] = 1'b1;
                default: tx[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic arm();
        first_hs = -1; first_v = -1; last_v = -1; n_valid = 0; done_cnt = 0;
        ready_run = 0;
        runs.delete(); rx_sym.delete(); rx_done.delete();
        exp_sym.delete(); exp_done.delete();
    endtask

    // ---------------- driver ----------------
    task automatic send_frame(input bit gaps, input bit tail_noise, input int nbits);
        int guard;
        int max_guard = 0;
        for (int i = 0; i < nbits; i++) begin
            if (gaps && i[0]) begin
                bit_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bit_in_valid = 1'b1;
            bit_in       = tx[i];
            guard = 0;
            while (!bit_in_ready && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard > max_guard) max_guard = guard;
            @(posedge clk); #1;
        end
        bit_in_valid = 1'b0;
        check("ready_wait_bounded", (max_guard < 100), 1);
        if (tail_noise && nbits == FRAME_LEN) begin
            for (int t = 0; t < TAIL_LEN - 2; t++) begin
                bit_in_valid = 1'b1;
                bit_in       = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            bit_in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 3000 && done_cnt < target; k++) @(posedge clk);
        check("frame_done_count", done_cnt, target);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, rx_sym.size(), exp_sym.size());
        for (int n = 0; n < rx_sym.size() && n < exp_sym.size(); n++) begin
            check($sformatf("%s_sym%0d", tag, n), rx_sym[n], exp_sym[n]);
            check($sformatf("%s_done%0d", tag, n), rx_done[n], exp_done[n]);
        end
    endtask

    task automatic check_impulse_prefix(input string tag, input int base);
        for (int k = 0; k < 7; k++) begin
            if (base + k < rx_sym.size())
                check($sformatf("%s_imp%0d", tag, k), rx_sym[base + k], imp_syms[k]);
            else
                check($sformatf("%s_imp%0d_missing", tag, k), 0, 1);
        end
    endtask

    task automatic check_run(input string tag, input int idx);
        if (idx < runs.size()) check(tag, runs[idx], TAIL_LEN);
        else check({tag, "_missing"}, 0, 1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        #2;
        check("rst_ready", bit_in_ready, 0);
        check("rst_valid", d_out_valid, 0);
        check("rst_dout", d_out, 0);
        check("rst_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1 RSTn = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", bit_in_ready, 1);

        // Impulse frame, continuous valid.
        arm(); fill(0); model_frame();
        send_frame(1'b0, 1'b0, FRAME_LEN);
        wait_done(1);
        compare_stream("impulse");
        check_impulse_prefix("impulse", 0);
        check("impulse_latency", first_v, first_hs);
        check_run("impulse_tail_ready_low", 0);

        // All-zero frame: one contiguous 544-cycle valid window.
        arm(); fill(1); model_frame();
        send_frame(1'b0, 1'b0, FRAME_LEN);
        wait_done(1);
        compare_stream("zeros");
        check("zeros_nvalid", n_valid, FS);
        check("zeros_span", last_v - first_v + 1, FS);
        check("zeros_latency", first_v, first_hs);

        // All-ones frame, then an impulse frame back to back.
        arm(); fill(2); model_frame();
        send_frame(1'b0, 1'b0, FRAME_LEN);
        fill(0); model_frame();
        send_frame(1'b0, 1'b0, FRAME_LEN);
        wait_done(2);
        compare_stream("ones_imp");
        for (int k = 0; k < 7; k++)
            check($sformatf("ones_prefix%0d", k), rx_sym[k], ones_syms[k]);
        check_impulse_prefix("b2b", FS);
        check("b2b_nvalid", n_valid, 2 * FS);
        check_run("ones_tail_ready_low", 0);
        check_run("b2b_tail_ready_low", 1);

        // Random bits with valid gaps in DATA and noise on bit_in during TAIL.
        arm(); fill(3); model_frame();
        send_frame(1'b1, 1'b1, FRAME_LEN);
        wait_done(1);
        compare_stream("gaps");
        check("gaps_nvalid", n_valid, FS);
        check("gaps_span", last_v - first_v + 1, FS + FRAME_LEN / 2);
        check_run("gaps_tail_ready_low", 0);

        // Reset after 200 bits of an all-ones frame.
        arm(); fill(2);
        send_frame(1'b0, 1'b0, 200);
        #2;
        check("prerst_valid", d_out_valid, 1);
        RSTn = 1'b0;
        #1;
        check("midrst_valid", d_out_valid, 0);
        check("midrst_dout", d_out, 0);
        check("midrst_ready", bit_in_ready, 0);
        check("midrst_done", frame_done, 0);
        repeat (2) @(posedge clk);
        #1 RSTn = 1'b1;
        @(posedge clk); #1;
        arm(); fill(0); model_frame();
        send_frame(1'b0, 1'b0, FRAME_LEN);
        wait_done(1);
        compare_stream("postrst");
        check_impulse_prefix("postrst", 0);

`ifdef CONV_ENC_ERR_INJ_EN
        // Error injection on symbol 10 of an all-zero frame.
        arm(); fill(1); model_frame();
        exp_sym[10] = 2'b01;
        err_inj_en = 1'b1; err_inj_idx = 16'd10; err_inj_mask = 2'b01;
        send_frame(1'b0, 1'b0, FRAME_LEN);
        wait_done(1);
        err_inj_en = 1'b0;
        compare_stream("errinj");
`endif

        check("dout_hold", hold_err, 0);
        check("stray_frame_done", stray_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
